pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline.
- Drives the pipeline-buffer control inputs: disable_IR, kill, stall, and a global freeze enable.
- Drives the PC enable and the ID-stage operand forwarding selects.
- Runs a small FSM that freezes the whole pipeline while data memory has not acknowledged an access. A watchdog flags a hung memory.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_fwd_sel.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

  typedef logic [1:0] fwd_sel_t;
  typedef logic [4:0] reg_idx_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EX  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b11;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status in, hazard/forwarding controls out
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  reg_idx_t Rs_ID;
  reg_idx_t Rt_ID;
  logic     uses_Rs_ID;
  logic     uses_Rt_ID;
  reg_idx_t Rd_EX;
  logic     RegWr_EX;
  logic     MemRd_EX;
  reg_idx_t Rd_MEM;
  logic     RegWr_MEM;
  logic     MemRd_MEM;
  logic     MemWr_MEM;
  reg_idx_t Rd_WB;
  logic     RegWr_WB;
  logic     take_branch_ID;
  logic     mem_ready;
  fwd_sel_t ForwardA;
  fwd_sel_t ForwardB;
  logic     disable_PC;
  logic     disable_IR;
  logic     kill;
  logic     stall;
  logic     freeze;
  logic     mem_err;

  // Controller side
  modport master (
    input  Rs_ID, Rt_ID, uses_Rs_ID, uses_Rt_ID, Rd_EX, RegWr_EX, MemRd_EX,
           Rd_MEM, RegWr_MEM, MemRd_MEM, MemWr_MEM, Rd_WB, RegWr_WB,
           take_branch_ID, mem_ready,
    output ForwardA, ForwardB, disable_PC, disable_IR, kill, stall, freeze, mem_err
  );

  // Pipeline datapath side
  modport slave (
    output Rs_ID, Rt_ID, uses_Rs_ID, uses_Rt_ID, Rd_EX, RegWr_EX, MemRd_EX,
           Rd_MEM, RegWr_MEM, MemRd_MEM, MemWr_MEM, Rd_WB, RegWr_WB,
           take_branch_ID, mem_ready,
    input  ForwardA, ForwardB, disable_PC, disable_IR, kill, stall, freeze, mem_err
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// rtl/pipeline_hazard_ctrl_fwd_sel.sv - per-operand forwarding priority mux (EX > MEM > WB)
module pipeline_hazard_ctrl_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
(
  input  reg_idx_t src,
  input  reg_idx_t rd_ex,
  input  logic     regwr_ex,
  input  logic     memrd_ex,
  input  reg_idx_t rd_mem,
  input  logic     regwr_mem,
  input  reg_idx_t rd_wb,
  input  logic     regwr_wb,
  output fwd_sel_t sel
);

  // A load in EX has no data yet; the load-use stall covers it instead.
  always_comb begin
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (regwr_ex && !memrd_ex && rd_ex == src)
        sel = FWD_EX;
      else if (regwr_mem && rd_mem == src)
        sel = FWD_MEM;
      else if (regwr_wb && rd_wb == src)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/kill/freeze sequencing, forwarding, memory watchdog (option HAZARD_PERF_CNT_EN)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int PERF_W      = 32
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  pipeline_hazard_ctrl_if.master    hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]         stall_cycles,
  output logic [PERF_W-1:0]         kill_count,
  output logic [PERF_W-1:0]         freeze_cycles
`endif
);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_busy;
  logic             lu;

  assign mem_busy = (hz.MemRd_MEM | hz.MemWr_MEM) & ~hz.mem_ready;

  assign lu = hz.MemRd_EX & hz.RegWr_EX & (hz.Rd_EX != 5'd0) &
              ((hz.uses_Rs_ID & (hz.Rs_ID == hz.Rd_EX)) |
               (hz.uses_Rt_ID & (hz.Rt_ID == hz.Rd_EX)));

  assign hz.freeze     = (state == ST_TIMEOUT) | mem_busy;
  assign hz.disable_PC = hz.freeze | lu;
  assign hz.disable_IR = hz.freeze | lu;
  assign hz.stall      = lu & ~hz.freeze;
  assign hz.kill       = hz.take_branch_ID & ~lu & ~hz.freeze;
  assign hz.mem_err    = (state == ST_TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            state    <= ST_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_TIMEOUT: state <= ST_TIMEOUT;
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  pipeline_hazard_ctrl_fwd_sel u_fwd_a (
    .src(hz.Rs_ID), .rd_ex(hz.Rd_EX), .regwr_ex(hz.RegWr_EX), .memrd_ex(hz.MemRd_EX),
    .rd_mem(hz.Rd_MEM), .regwr_mem(hz.RegWr_MEM), .rd_wb(hz.Rd_WB), .regwr_wb(hz.RegWr_WB),
    .sel(hz.ForwardA)
  );

  pipeline_hazard_ctrl_fwd_sel u_fwd_b (
    .src(hz.Rt_ID), .rd_ex(hz.Rd_EX), .regwr_ex(hz.RegWr_EX), .memrd_ex(hz.MemRd_EX),
    .rd_mem(hz.Rd_MEM), .regwr_mem(hz.RegWr_MEM), .rd_wb(hz.Rd_WB), .regwr_wb(hz.RegWr_WB),
    .sel(hz.ForwardB)
  );

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters, one increment per qualifying cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles  <= '0;
      kill_count    <= '0;
      freeze_cycles <= '0;
    end else begin
      if (hz.stall && stall_cycles != {PERF_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
      if (hz.kill && kill_count != {PERF_W{1'b1}})
        kill_count <= kill_count + 1'b1;
      if (hz.freeze && freeze_cycles != {PERF_W{1'b1}})
        freeze_cycles <= freeze_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if hif();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] kill_count;
  logic [31:0] freeze_cycles;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hif.master)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .kill_count(kill_count),
    .freeze_cycles(freeze_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.Rs_ID = 0; hif.Rt_ID = 0; hif.uses_Rs_ID = 0; hif.uses_Rt_ID = 0;
    hif.Rd_EX = 0; hif.RegWr_EX = 0; hif.MemRd_EX = 0;
    hif.Rd_MEM = 0; hif.RegWr_MEM = 0; hif.MemRd_MEM = 0; hif.MemWr_MEM = 0;
    hif.Rd_WB = 0; hif.RegWr_WB = 0; hif.take_branch_ID = 0; hif.mem_ready = 0;
  endtask

  task automatic set_load_use();
    hif.MemRd_EX = 1; hif.RegWr_EX = 1; hif.Rd_EX = 5;
    hif.Rs_ID = 5; hif.uses_Rs_ID = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, hif.disable_PC, hif.disable_IR, hif.stall, hif.kill, hif.freeze}, {27'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b1;
    clear_inputs();
    #1 reset_n = 1'b0;
    #1;
    // ctrl vector: {disable_PC, disable_IR, stall, kill, freeze}
    check_ctrl("reset_ctrl", 5'b00000);
    check("reset_fwda", hif.ForwardA, 0);
    check("reset_fwdb", hif.ForwardB, 0);
    check("reset_mem_err", hif.mem_err, 0);
    #10 reset_n = 1'b1;

    // load-use: one stall cycle, then the load sits in MEM and forwards
    tick();
    set_load_use(); hif.mem_ready = 1;
    #1 check_ctrl("lu_stall", 5'b11100);
    tick();
    clear_inputs(); hif.mem_ready = 1; hif.Rs_ID = 5; hif.uses_Rs_ID = 1;
    hif.MemRd_MEM = 1; hif.RegWr_MEM = 1; hif.Rd_MEM = 5;
    #1 check_ctrl("lu_retry", 5'b00000);
    check("lu_retry_fwda", hif.ForwardA, 2'b10);

    // forwarding priority
    tick();
    clear_inputs(); hif.mem_ready = 1;
    hif.Rs_ID = 3; hif.Rt_ID = 3; hif.uses_Rs_ID = 1;
    hif.RegWr_EX = 1; hif.Rd_EX = 3;
    hif.RegWr_MEM = 1; hif.Rd_MEM = 3;
    hif.RegWr_WB = 1; hif.Rd_WB = 3;
    #1 check("fwd_ex", hif.ForwardA, 2'b01);
    check("fwd_ex_b", hif.ForwardB, 2'b01);
    hif.RegWr_EX = 0;
    #1 check("fwd_mem", hif.ForwardA, 2'b10);
    hif.RegWr_MEM = 0;
    #1 check("fwd_wb", hif.ForwardA, 2'b11);
    hif.Rs_ID = 0;
    #1 check("fwd_r0", hif.ForwardA, 2'b00);
    check("fwd_wb_b", hif.ForwardB, 2'b11);
    hif.Rs_ID = 3; hif.RegWr_EX = 1; hif.MemRd_EX = 1; hif.RegWr_MEM = 1;
    #1 check("fwd_load_ex_skipped", hif.ForwardA, 2'b10);
    check_ctrl("fwd_load_ex_stall", 5'b11100);

    // branch behind a load: stall first, kill on the retry
    tick();
    clear_inputs(); hif.mem_ready = 1;
    set_load_use(); hif.take_branch_ID = 1;
    #1 check_ctrl("br_lu_stall", 5'b11100);
    tick();
    clear_inputs(); hif.mem_ready = 1; hif.take_branch_ID = 1;
    hif.MemRd_MEM = 1; hif.RegWr_MEM = 1; hif.Rd_MEM = 5;
    #1 check_ctrl("br_retry_kill", 5'b00010);

    // memory wait: 3 frozen cycles, freeze overrides lu and branch
    tick();
    clear_inputs(); set_load_use(); hif.take_branch_ID = 1;
    hif.MemRd_MEM = 1; hif.mem_ready = 0;
    #1 check_ctrl("mw_c0", 5'b11001);
    tick();
    #1 check_ctrl("mw_c1", 5'b11001);
    tick();
    #1 check_ctrl("mw_c2", 5'b11001);
    tick();
    hif.mem_ready = 1;
    #1 check_ctrl("mw_ready", 5'b11100);
    tick();
    clear_inputs();
    #1 check_ctrl("mw_idle", 5'b00000);
    check("mw_mem_err", hif.mem_err, 0);

    // watchdog: MEM_TIMEOUT=4 gives five frozen cycles in RUN/MEM_WAIT, then TIMEOUT
    tick();
    clear_inputs(); hif.MemRd_MEM = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("to_wait_freeze", hif.freeze, 1);
      check("to_wait_err", hif.mem_err, 0);
      tick();
    end
    #1 check("to_err", hif.mem_err, 1);
    check("to_freeze", hif.freeze, 1);
    clear_inputs(); hif.mem_ready = 1; hif.take_branch_ID = 1;
    tick();
    #1 check_ctrl("to_sticky", 5'b11001);
    check("to_sticky_err", hif.mem_err, 1);
    #1 reset_n = 1'b0;
    clear_inputs();
    #1 check_ctrl("to_async_reset", 5'b00000);
    check("to_async_reset_err", hif.mem_err, 0);
    @(negedge clk) reset_n = 1'b1;

`ifdef HAZARD_PERF_CNT_EN
    tick();
    hif.mem_ready = 1; set_load_use();
    tick();
    clear_inputs();
    tick();
    hif.mem_ready = 1; set_load_use();
    tick();
    clear_inputs(); hif.take_branch_ID = 1;
    tick();
    clear_inputs();
    tick();
    check("perf_stall", stall_cycles, 2);
    check("perf_kill", kill_count, 1);
    check("perf_freeze", freeze_cycles, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
